// File: rtl/bus_port_fifo_if.sv
// Host/bus signal bundle for the bus port FIFO pair.
// The slave modport is the FIFO's view. The master modport is the host and bus side.
interface bus_port_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    localparam int cw = $clog2(depth) + 1;

    logic               host_wr;
    logic [pckg_sz-1:0] host_din;
    logic               host_rd;
    logic [pckg_sz-1:0] host_dout;
    logic               clr_err;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               tx_full;
    logic               rx_empty;
    logic [cw-1:0]      tx_count;
    logic [cw-1:0]      rx_count;
    logic               tx_ovf;
    logic               tx_unf;
    logic               rx_ovf;
    logic               rx_unf;

    modport slave (
        input  host_wr, host_din, host_rd, clr_err, pop, push, D_push,
        output host_dout, pndng, D_pop, tx_full, rx_empty, tx_count, rx_count,
               tx_ovf, tx_unf, rx_ovf, rx_unf
    );

    modport master (
        output host_wr, host_din, host_rd, clr_err, pop, push, D_push,
        input  host_dout, pndng, D_pop, tx_full, rx_empty, tx_count, rx_count,
               tx_ovf, tx_unf, rx_ovf, rx_unf
    );
endinterface

// File: rtl/bus_port_fifo.sv
// Bus port with independent first-word-fall-through TX (host->bus) and RX (bus->host)
// FIFOs, occupancy counters and sticky overflow/underflow flags.
module port_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [pckg_sz-1:0]       din,
    input  logic                     rd,
    output logic [pckg_sz-1:0]       dout,
    output logic [$clog2(depth):0]   count,
    output logic                     ovf_evt,
    output logic                     unf_evt
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0]   full_level = (aw+1)'(depth);
    localparam logic [aw:0]   cnt_one    = (aw+1)'(1);
    localparam logic [aw-1:0] ptr_one    = (aw)'(1);

    logic [pckg_sz-1:0] mem [depth];
    logic [aw-1:0]      wr_ptr;
    logic [aw-1:0]      rd_ptr;
    logic [aw:0]        cnt;
    logic               empty;
    logic               full;
    logic               rd_ok;
    logic               wr_ok;

    // A write into a full FIFO still succeeds when a read frees the head slot in the same cycle.
    assign empty   = (cnt == '0);
    assign full    = (cnt == full_level);
    assign rd_ok   = rd && !empty;
    assign wr_ok   = wr && (!full || rd_ok);
    assign ovf_evt = wr && !wr_ok;
    assign unf_evt = rd && empty;
    assign count   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + cnt_one;
                2'b01:   cnt <= cnt - cnt_one;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module bus_port_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_port_fifo_if.slave        bus
);
    localparam int cw = $clog2(depth) + 1;
    localparam logic [cw-1:0] full_level = (cw)'(depth);

    logic          tx_ovf_evt;
    logic          tx_unf_evt;
    logic          rx_ovf_evt;
    logic          rx_unf_evt;
    logic [cw-1:0] tx_cnt;
    logic [cw-1:0] rx_cnt;
    logic          tx_ovf_q;
    logic          tx_unf_q;
    logic          rx_ovf_q;
    logic          rx_unf_q;

    port_fifo #(.pckg_sz(pckg_sz), .depth(depth)) tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (bus.host_wr),
        .din     (bus.host_din),
        .rd      (bus.pop),
        .dout    (bus.D_pop),
        .count   (tx_cnt),
        .ovf_evt (tx_ovf_evt),
        .unf_evt (tx_unf_evt)
    );

    port_fifo #(.pckg_sz(pckg_sz), .depth(depth)) rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (bus.push),
        .din     (bus.D_push),
        .rd      (bus.host_rd),
        .dout    (bus.host_dout),
        .count   (rx_cnt),
        .ovf_evt (rx_ovf_evt),
        .unf_evt (rx_unf_evt)
    );

    assign bus.tx_count = tx_cnt;
    assign bus.rx_count = rx_cnt;
    assign bus.pndng    = (tx_cnt != '0);
    assign bus.tx_full  = (tx_cnt == full_level);
    assign bus.rx_empty = (rx_cnt == '0);
    assign bus.tx_ovf   = tx_ovf_q;
    assign bus.tx_unf   = tx_unf_q;
    assign bus.rx_ovf   = rx_ovf_q;
    assign bus.rx_unf   = rx_unf_q;

    // Sticky flags: a new error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_q <= 1'b0;
            tx_unf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_evt | (tx_ovf_q & ~bus.clr_err);
            tx_unf_q <= tx_unf_evt | (tx_unf_q & ~bus.clr_err);
            rx_ovf_q <= rx_ovf_evt | (rx_ovf_q & ~bus.clr_err);
            rx_unf_q <= rx_unf_evt | (rx_unf_q & ~bus.clr_err);
        end
    end
endmodule

// File: tb/tb_bus_port_fifo.sv
// Randomized and directed bench for bus_port_fifo against a queue-based reference model.
module tb_bus_port_fifo;
    localparam int pckg_sz = 16;
    localparam int depth   = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [pckg_sz-1:0] tx_q[$];
    logic [pckg_sz-1:0] rx_q[$];
    bit m_tx_ovf, m_tx_unf, m_rx_ovf, m_rx_unf;

    bus_port_fifo_if #(.pckg_sz(pckg_sz), .depth(depth)) bus ();

    bus_port_fifo #(.pckg_sz(pckg_sz), .depth(depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("pndng",     32'(bus.pndng),     32'(tx_q.size() != 0));
        checkOutput("D_pop",     32'(bus.D_pop),     (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'h0);
        checkOutput("tx_count",  32'(bus.tx_count),  32'(tx_q.size()));
        checkOutput("tx_full",   32'(bus.tx_full),   32'(tx_q.size() == depth));
        checkOutput("host_dout", 32'(bus.host_dout), (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'h0);
        checkOutput("rx_count",  32'(bus.rx_count),  32'(rx_q.size()));
        checkOutput("rx_empty",  32'(bus.rx_empty),  32'(rx_q.size() == 0));
        checkOutput("tx_ovf",    32'(bus.tx_ovf),    32'(m_tx_ovf));
        checkOutput("tx_unf",    32'(bus.tx_unf),    32'(m_tx_unf));
        checkOutput("rx_ovf",    32'(bus.rx_ovf),    32'(m_rx_ovf));
        checkOutput("rx_unf",    32'(bus.rx_unf),    32'(m_rx_unf));
    endtask

    task automatic modelReset();
        tx_q.delete();
        rx_q.delete();
        m_tx_ovf = 0;
        m_tx_unf = 0;
        m_rx_ovf = 0;
        m_rx_unf = 0;
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, then compare.
    task automatic applyStimulus(input bit wr, input logic [pckg_sz-1:0] din, input bit hrd,
                                 input bit pop, input bit push, input logic [pckg_sz-1:0] dpush,
                                 input bit clr);
        bit tx_rd, tx_wr, rx_rd, rx_wr;
        bit tx_ovf_e, tx_unf_e, rx_ovf_e, rx_unf_e;
        bus.host_wr  = wr;
        bus.host_din = din;
        bus.host_rd  = hrd;
        bus.pop      = pop;
        bus.push     = push;
        bus.D_push   = dpush;
        bus.clr_err  = clr;
        @(posedge clk);
        tx_rd    = pop && (tx_q.size() > 0);
        tx_wr    = wr && ((tx_q.size() < depth) || tx_rd);
        tx_unf_e = pop && (tx_q.size() == 0);
        tx_ovf_e = wr && !tx_wr;
        rx_rd    = hrd && (rx_q.size() > 0);
        rx_wr    = push && ((rx_q.size() < depth) || rx_rd);
        rx_unf_e = hrd && (rx_q.size() == 0);
        rx_ovf_e = push && !rx_wr;
        if (tx_rd) void'(tx_q.pop_front());
        if (tx_wr) tx_q.push_back(din);
        if (rx_rd) void'(rx_q.pop_front());
        if (rx_wr) rx_q.push_back(dpush);
        m_tx_ovf = tx_ovf_e || (m_tx_ovf && !clr);
        m_tx_unf = tx_unf_e || (m_tx_unf && !clr);
        m_rx_ovf = rx_ovf_e || (m_rx_ovf && !clr);
        m_rx_unf = rx_unf_e || (m_rx_unf && !clr);
        #1;
        checkState();
    endtask

    initial begin
        reset        = 1'b0;
        bus.host_wr  = 1'b0;
        bus.host_din = '0;
        bus.host_rd  = 1'b0;
        bus.pop      = 1'b0;
        bus.push     = 1'b0;
        bus.D_push   = '0;
        bus.clr_err  = 1'b0;
        modelReset();
        #12;
        checkState();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        checkState();

        // Single write then pop
        applyStimulus(1, 16'hA001, 0, 0, 0, 0, 0);
        checkOutput("a001_dpop", 32'(bus.D_pop), 32'hA001);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("a001_pndng", 32'(bus.pndng), 32'h0);

        // Nine writes into an 8-deep FIFO, then drain
        for (int i = 0; i < 9; i++) applyStimulus(1, 16'(i), 0, 0, 0, 0, 0);
        checkOutput("ovf_full", 32'(bus.tx_full), 32'h1);
        checkOutput("ovf_flag", 32'(bus.tx_ovf), 32'h1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_order", 32'(bus.D_pop), 32'(i));
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Full FIFO with simultaneous write and pop across pointer wrap
        for (int i = 0; i < 8; i++) applyStimulus(1, 16'(16'h0100 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 16'hBEEF, 0, 1, 0, 0, 0);
        checkOutput("wrap_count", 32'(bus.tx_count), 32'd8);
        checkOutput("wrap_ovf", 32'(bus.tx_ovf), 32'h0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("beef_last", 32'(bus.D_pop), 32'hBEEF);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        // Pop on empty with simultaneous write
        applyStimulus(1, 16'h1234, 0, 1, 0, 0, 0);
        checkOutput("unf_flag", 32'(bus.tx_unf), 32'h1);
        checkOutput("unf_dpop", 32'(bus.D_pop), 32'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("unf_clr", 32'(bus.tx_unf), 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        checkOutput("set_wins", 32'(bus.tx_unf), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // RX path
        applyStimulus(0, 0, 0, 0, 1, 16'h5555, 0);
        applyStimulus(0, 0, 0, 0, 1, 16'hAAAA, 0);
        checkOutput("rx_head0", 32'(bus.host_dout), 32'h5555);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("rx_head1", 32'(bus.host_dout), 32'hAAAA);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("rx_drained", 32'(bus.rx_empty), 32'h1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("rx_unf", 32'(bus.rx_unf), 32'h1);

        // Randomized traffic, biased so both FIFOs fill and drain
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 55), 16'($urandom),
                          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 45),
                          ($urandom_range(0, 99) < 55), 16'($urandom),
                          ($urandom_range(0, 7) == 0));
        end

        // Load TX with 3 and RX with 2, then assert reset between edges
        for (int i = 0; i < depth; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 16'h0C01, 0, 0, 1, 16'h0D01, 0);
        applyStimulus(1, 16'h0C02, 0, 0, 1, 16'h0D02, 0);
        applyStimulus(1, 16'h0C03, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_tx", 32'(bus.tx_count), 32'd3);
        checkOutput("pre_rst_rx", 32'(bus.rx_count), 32'd2);
        bus.host_wr = 1'b0;
        bus.push    = 1'b0;
        #3 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async_tx", 32'(bus.tx_count), 32'h0);
        checkOutput("rst_async_rxe", 32'(bus.rx_empty), 32'h1);
        checkState();
        @(posedge clk);
        #1;
        checkState();
        reset = 1'b1;
        applyStimulus(1, 16'h7777, 0, 0, 1, 16'h8888, 0);
        checkOutput("post_rst_wr", 32'(bus.D_pop), 32'h7777);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_port_fifo.md
BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 Parameter pckg_sz, default 16: width of one bus packet in bits.
REQ-002 Parameter depth, default 8: entries per FIFO; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release is synchronised to clk.
REQ-005 host_wr  input  1  host request to enqueue host_din into the TX FIFO.
REQ-006 host_din  input  pckg_sz  packet to send onto the bus.
REQ-007 host_rd  input  1  host request to dequeue the RX FIFO head.
REQ-008 host_dout  output  pckg_sz  RX FIFO head packet.
REQ-009 clr_err  input  1  clears all sticky error flags.
REQ-010 pndng  output  1  to the bus: TX FIFO not empty.
REQ-011 D_pop  output  pckg_sz  to the bus: TX FIFO head packet.
REQ-012 pop  input  1  from the bus: head consumed this cycle.
REQ-013 push  input  1  from the bus: D_push valid this cycle.
REQ-014 D_push  input  pckg_sz  packet delivered by the bus.
REQ-015 tx_full, rx_empty  output  1 each  FIFO status.
REQ-016 tx_count, rx_count  output  $clog2(depth)+1  occupancy.
REQ-017 tx_ovf, tx_unf, rx_ovf, rx_unf  output  1 each  sticky error flags.

Function
REQ-018 TX and RX SHALL be independent circular FIFOs of depth entries, each with read and write pointers that wrap from depth-1 to 0.
REQ-019 Both FIFOs SHALL be first-word-fall-through: D_pop and host_dout SHALL equal the head entry with no read latency.
REQ-020 While a FIFO is empty, its data output SHALL be all zeros.
REQ-021 pndng SHALL equal (tx_count != 0), combinational from registered state.
REQ-022 host_wr with tx_count < depth SHALL store host_din; it SHALL be visible on D_pop the next cycle if the FIFO was empty.
REQ-023 host_wr while tx_full SHALL be dropped and SHALL set tx_ovf, unless pop is accepted in the same cycle. In that case both actions occur and the count is unchanged.
REQ-024 pop while TX is empty SHALL be ignored and SHALL set tx_unf; a simultaneous host_wr is still accepted.
REQ-025 pop and host_wr both accepted in one cycle SHALL leave tx_count unchanged.
REQ-026 push with rx_count < depth SHALL store D_push; push while full SHALL be dropped and set rx_ovf, unless host_rd is accepted in the same cycle.
REQ-027 host_rd while RX is empty SHALL be ignored and SHALL set rx_unf.
REQ-028 Counts SHALL range 0..depth, never wrap, and change by at most 1 per cycle.
REQ-029 tx_full SHALL be (tx_count == depth); rx_empty SHALL be (rx_count == 0).
REQ-030 Sticky flags SHALL remain set until clr_err is sampled high.
REQ-031 An error event in the same cycle as clr_err SHALL leave its flag set (set wins).
REQ-032 Storage contents SHALL not need reset; only pointers, counts and flags are reset.

Reset
REQ-033 While reset is low: counts = 0, pointers = 0, pndng = 0, D_pop = 0, host_dout = 0, tx_full = 0, rx_empty = 1, all error flags = 0.
REQ-034 Assertion of reset mid-operation SHALL discard all queued packets in both FIFOs.
REQ-035 The first accepted operation SHALL be on the first rising clk edge after reset is deasserted.

Verification
REQ-036 Reset, then host_wr 0xA001 in one cycle -> next cycle pndng = 1, D_pop = 0xA001, tx_count = 1; pop in one cycle -> pndng = 0, D_pop = 0.
REQ-037 Write 9 packets 0x0000..0x0008 with depth = 8 -> tx_full = 1, tx_ovf = 1, and the 8 pops yield 0x0000..0x0007 in order.
REQ-038 TX full, host_wr 0xBEEF together with pop in the same cycle -> tx_count stays 8, tx_ovf stays 0, 0xBEEF is popped last; run 20 such cycles to exercise pointer wrap.
REQ-039 pop on empty TX with a simultaneous host_wr 0x1234 -> tx_unf = 1, tx_count = 1, D_pop = 0x1234; clr_err -> tx_unf = 0.
REQ-040 push 0x5555 and 0xAAAA on consecutive cycles, then host_rd twice -> host_dout shows 0x5555 then 0xAAAA, rx_empty = 1; one more host_rd -> rx_unf = 1.
REQ-041 TX holding 3 packets and RX holding 2, assert reset low mid-cycle -> all outputs take the REQ-033 values immediately, without waiting for a clk edge.
